// File: rtl/dtmf_pkg.sv
// Shared definitions for the DTMF transmitter: tone codes, group frequencies,
// phase-increment helper and the sequencing state type.
package dtmf_pkg;

    localparam logic [4:0] TONE_0    = 5'd0;
    localparam logic [4:0] TONE_1    = 5'd1;
    localparam logic [4:0] TONE_2    = 5'd2;
    localparam logic [4:0] TONE_3    = 5'd3;
    localparam logic [4:0] TONE_4    = 5'd4;
    localparam logic [4:0] TONE_5    = 5'd5;
    localparam logic [4:0] TONE_6    = 5'd6;
    localparam logic [4:0] TONE_7    = 5'd7;
    localparam logic [4:0] TONE_8    = 5'd8;
    localparam logic [4:0] TONE_9    = 5'd9;
    localparam logic [4:0] TONE_A    = 5'd10;
    localparam logic [4:0] TONE_B    = 5'd11;
    localparam logic [4:0] TONE_C    = 5'd12;
    localparam logic [4:0] TONE_D    = 5'd13;
    localparam logic [4:0] TONE_STAR = 5'd14;
    localparam logic [4:0] TONE_HASH = 5'd15;
    localparam logic [4:0] NO_TONE   = 5'd16;

    localparam int ROW_HZ_0 = 697;
    localparam int ROW_HZ_1 = 770;
    localparam int ROW_HZ_2 = 852;
    localparam int ROW_HZ_3 = 941;
    localparam int COL_HZ_0 = 1209;
    localparam int COL_HZ_1 = 1336;
    localparam int COL_HZ_2 = 1477;
    localparam int COL_HZ_3 = 1633;

    typedef enum logic [1:0] {IDLE, ON, OFF, DRAIN} state_t;

    // round(freq * 2^w / fs), evaluated at elaboration time
    function automatic longint phase_inc(input int freq, input int fs, input int w);
        longint num;
        num = (longint'(freq) << w) + longint'(fs / 2);
        return num / longint'(fs);
    endfunction

    function automatic logic [1:0] row_of(input logic [4:0] code);
        case (code)
            TONE_1, TONE_2, TONE_3, TONE_A: return 2'd0;
            TONE_4, TONE_5, TONE_6, TONE_B: return 2'd1;
            TONE_7, TONE_8, TONE_9, TONE_C: return 2'd2;
            default:                        return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] col_of(input logic [4:0] code);
        case (code)
            TONE_1, TONE_4, TONE_7, TONE_STAR: return 2'd0;
            TONE_2, TONE_5, TONE_8, TONE_0:    return 2'd1;
            TONE_3, TONE_6, TONE_9, TONE_HASH: return 2'd2;
            default:                           return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/dtmf_sine_rom.sv
// 256-entry signed 16-bit sine ROM with two registered read ports, built from
// a quarter-wave table using sine symmetry.
module dtmf_sine_rom (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         lo_addr,
    input  logic [7:0]         hi_addr,
    output logic signed [15:0] lo_data,
    output logic signed [15:0] hi_data
);

    // round(32767 * sin(2*pi*k/256)) for k = 0..64
    function automatic logic [14:0] quarter(input logic [6:0] k);
        logic [14:0] q;
        case (k)
            7'd0:  q = 15'd0;     7'd1:  q = 15'd804;   7'd2:  q = 15'd1608;  7'd3:  q = 15'd2410;
            7'd4:  q = 15'd3212;  7'd5:  q = 15'd4011;  7'd6:  q = 15'd4808;  7'd7:  q = 15'd5602;
            7'd8:  q = 15'd6393;  7'd9:  q = 15'd7179;  7'd10: q = 15'd7962;  7'd11: q = 15'd8739;
            7'd12: q = 15'd9512;  7'd13: q = 15'd10278; 7'd14: q = 15'd11039; 7'd15: q = 15'd11793;
            7'd16: q = 15'd12539; 7'd17: q = 15'd13279; 7'd18: q = 15'd14010; 7'd19: q = 15'd14732;
            7'd20: q = 15'd15446; 7'd21: q = 15'd16151; 7'd22: q = 15'd16846; 7'd23: q = 15'd17530;
            7'd24: q = 15'd18204; 7'd25: q = 15'd18868; 7'd26: q = 15'd19519; 7'd27: q = 15'd20159;
            7'd28: q = 15'd20787; 7'd29: q = 15'd21403; 7'd30: q = 15'd22005; 7'd31: q = 15'd22594;
            7'd32: q = 15'd23170; 7'd33: q = 15'd23731; 7'd34: q = 15'd24279; 7'd35: q = 15'd24811;
            7'd36: q = 15'd25329; 7'd37: q = 15'd25832; 7'd38: q = 15'd26319; 7'd39: q = 15'd26790;
            7'd40: q = 15'd27245; 7'd41: q = 15'd27683; 7'd42: q = 15'd28105; 7'd43: q = 15'd28510;
            7'd44: q = 15'd28898; 7'd45: q = 15'd29268; 7'd46: q = 15'd29621; 7'd47: q = 15'd29956;
            7'd48: q = 15'd30273; 7'd49: q = 15'd30571; 7'd50: q = 15'd30852; 7'd51: q = 15'd31113;
            7'd52: q = 15'd31356; 7'd53: q = 15'd31580; 7'd54: q = 15'd31785; 7'd55: q = 15'd31971;
            7'd56: q = 15'd32137; 7'd57: q = 15'd32285; 7'd58: q = 15'd32412; 7'd59: q = 15'd32521;
            7'd60: q = 15'd32609; 7'd61: q = 15'd32678; 7'd62: q = 15'd32728; 7'd63: q = 15'd32757;
            7'd64: q = 15'd32767;
            default: q = 15'd0;
        endcase
        return q;
    endfunction

    // Second quadrant mirrors the first; the lower half is the negated upper half
    function automatic logic signed [15:0] sine_at(input logic [7:0] a);
        logic [6:0]  k;
        logic [14:0] m;
        k = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        m = quarter(k);
        return a[7] ? -$signed({1'b0, m}) : $signed({1'b0, m});
    endfunction

    // NOTE: the table is constant logic, so only the output registers need a reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lo_data <= '0;
            hi_data <= '0;
        end else begin
            lo_data <= sine_at(lo_addr);
            hi_data <= sine_at(hi_addr);
        end
    end

endmodule

// File: rtl/dtmf_tone_gen.sv
// DTMF transmitter: tone burst, silent gap, then done. Define DTMF_GEN_TWIST_EN
// to scale the low-group tone by 3/4 before summing.
module dtmf_tone_gen
    import dtmf_pkg::*;
#(
    parameter int FS_HZ       = 8000,
    parameter int PHASE_W     = 24,
    parameter int ON_SAMPLES  = 800,
    parameter int OFF_SAMPLES = 400
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [4:0]         tone_code,
    input  logic               sample_tick,
    output logic               busy,
    output logic               sample_valid,
    output logic signed [15:0] sample,
    output logic               done,
    output logic               err
);

    localparam int MAX_N = (ON_SAMPLES > OFF_SAMPLES) ? ON_SAMPLES : OFF_SAMPLES;
    localparam int CNT_W = $clog2(MAX_N + 1);

    localparam logic [PHASE_W-1:0] INC_R0 = PHASE_W'(phase_inc(ROW_HZ_0, FS_HZ, PHASE_W));
    localparam logic [PHASE_W-1:0] INC_R1 = PHASE_W'(phase_inc(ROW_HZ_1, FS_HZ, PHASE_W));
    localparam logic [PHASE_W-1:0] INC_R2 = PHASE_W'(phase_inc(ROW_HZ_2, FS_HZ, PHASE_W));
    localparam logic [PHASE_W-1:0] INC_R3 = PHASE_W'(phase_inc(ROW_HZ_3, FS_HZ, PHASE_W));
    localparam logic [PHASE_W-1:0] INC_C0 = PHASE_W'(phase_inc(COL_HZ_0, FS_HZ, PHASE_W));
    localparam logic [PHASE_W-1:0] INC_C1 = PHASE_W'(phase_inc(COL_HZ_1, FS_HZ, PHASE_W));
    localparam logic [PHASE_W-1:0] INC_C2 = PHASE_W'(phase_inc(COL_HZ_2, FS_HZ, PHASE_W));
    localparam logic [PHASE_W-1:0] INC_C3 = PHASE_W'(phase_inc(COL_HZ_3, FS_HZ, PHASE_W));

    function automatic logic [PHASE_W-1:0] row_inc(input logic [1:0] r);
        case (r)
            2'd0:    return INC_R0;
            2'd1:    return INC_R1;
            2'd2:    return INC_R2;
            default: return INC_R3;
        endcase
    endfunction

    function automatic logic [PHASE_W-1:0] col_inc(input logic [1:0] c);
        case (c)
            2'd0:    return INC_C0;
            2'd1:    return INC_C1;
            2'd2:    return INC_C2;
            default: return INC_C3;
        endcase
    endfunction

    state_t              state, state_nxt;
    logic                accept;
    logic [PHASE_W-1:0]  lo_phase, hi_phase, lo_inc, hi_inc;
    logic [CNT_W-1:0]    cnt;
    logic                on_last, off_last, issue;
    logic                s1_valid, s1_zero, s1_last;
    logic signed [15:0]  rom_lo, rom_hi;
    logic signed [16:0]  lo_term, sum17;
    logic signed [15:0]  sample_nxt;

    assign on_last  = (cnt == CNT_W'(ON_SAMPLES - 1));
    assign off_last = (cnt == CNT_W'(OFF_SAMPLES - 1));
    assign issue    = sample_tick && ((state == ON) || (state == OFF));
    assign busy     = (state != IDLE);

    dtmf_sine_rom u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .lo_addr (lo_phase[PHASE_W-1 -: 8]),
        .hi_addr (hi_phase[PHASE_W-1 -: 8]),
        .lo_data (rom_lo),
        .hi_data (rom_hi)
    );

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE:  if (start && (tone_code < NO_TONE)) begin
                       accept    = 1'b1;
                       state_nxt = ON;
                   end
            ON:    if (sample_tick && on_last)  state_nxt = OFF;
            OFF:   if (sample_tick && off_last) state_nxt = DRAIN;
            DRAIN: if (done)                    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // 17-bit sum cannot overflow; halving brings it back into 16-bit range
    always_comb begin
`ifdef DTMF_GEN_TWIST_EN
        lo_term = (17'(rom_lo) >>> 1) + (17'(rom_lo) >>> 2);
`else
        lo_term = 17'(rom_lo);
`endif
        sum17      = lo_term + 17'(rom_hi);
        sample_nxt = 16'(sum17 >>> 1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            lo_phase     <= '0;
            hi_phase     <= '0;
            lo_inc       <= '0;
            hi_inc       <= '0;
            cnt          <= '0;
            s1_valid     <= 1'b0;
            s1_zero      <= 1'b0;
            s1_last      <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= (state == IDLE) && start && (tone_code >= NO_TONE);

            if (accept) begin
                lo_inc   <= row_inc(row_of(tone_code));
                hi_inc   <= col_inc(col_of(tone_code));
                lo_phase <= '0;
                hi_phase <= '0;
                cnt      <= '0;
            end else if (issue) begin
                if (state == ON) begin
                    lo_phase <= lo_phase + lo_inc;
                    hi_phase <= hi_phase + hi_inc;
                end
                if (((state == ON) && on_last) || ((state == OFF) && off_last))
                    cnt <= '0;
                else
                    cnt <= cnt + CNT_W'(1);
            end

            // Stage 1 flags travel alongside the registered ROM read
            s1_valid     <= issue;
            s1_zero      <= (state == OFF);
            s1_last      <= issue && (state == OFF) && off_last;
            sample_valid <= s1_valid;
            done         <= s1_valid && s1_last;
            if (s1_valid)
                sample <= s1_zero ? 16'sd0 : sample_nxt;
        end
    end

endmodule

// File: tb/tb_dtmf_tone_gen.sv
// Directed, scoreboard-based bench for dtmf_tone_gen (ON_SAMPLES=4, OFF_SAMPLES=2).
module tb_dtmf_tone_gen;

    localparam int ON_N  = 4;
    localparam int OFF_N = 2;

    logic               clk = 1'b0;
    logic               reset_n, start, sample_tick;
    logic [4:0]         tone_code;
    logic               busy, sample_valid, done, err;
    logic signed [15:0] sample;

    dtmf_tone_gen #(
        .FS_HZ(8000), .PHASE_W(24), .ON_SAMPLES(ON_N), .OFF_SAMPLES(OFF_N)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .tone_code    (tone_code),
        .sample_tick  (sample_tick),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample       (sample),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        bit last;
        int due;
    } exp_t;

    exp_t sb[$];
    int   err_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int rom_model(input int i);
        real v;
        v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(i) / 256.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(-v + 0.5);
    endfunction

    function automatic int model_sample(input int rinc, input int cinc, input int n);
        longint pl, ph;
        int     lo, hi;
        pl = (longint'(n) * longint'(rinc)) % (longint'(1) << 24);
        ph = (longint'(n) * longint'(cinc)) % (longint'(1) << 24);
        lo = rom_model(int'(pl >> 16));
        hi = rom_model(int'(ph >> 16));
`ifdef DTMF_GEN_TWIST_EN
        return ((lo >>> 1) + (lo >>> 2) + hi) >>> 1;
`else
        return (lo + hi) >>> 1;
`endif
    endfunction

    // Advance to the next falling edge and reconcile outputs with the scoreboard
    task automatic next_cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (sample_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", sample_valid, 0);
            end else begin
                e = sb.pop_front();
                check("valid_cycle", cyc, e.due);
                check("sample", sample, e.value);
                check("done", done, e.last);
            end
        end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                void'(sb.pop_front());
                check("sample_valid", sample_valid, 1);
            end
            check("done_quiet", done, 0);
        end
        if (err_q.size() > 0 && err_q[0] == cyc) begin
            void'(err_q.pop_front());
            check("err", err, 1);
        end else begin
            check("err_quiet", err, 0);
        end
    endtask

    task automatic tick_once(input int value, input bit last);
        sb.push_back('{value: value, last: last, due: cyc + 2});
        sample_tick = 1'b1;
        next_cycle();
        sample_tick = 1'b0;
    endtask

    task automatic run_digit(input int code, input int rinc, input int cinc, input int gap,
                             input bit tick_at_start, input int intrude_after);
        sample_tick = tick_at_start;
        start       = 1'b1;
        tone_code   = 5'(code);
        next_cycle();
        start       = 1'b0;
        sample_tick = 1'b0;
        check("busy_on", busy, 1);
        for (int n = 0; n < ON_N + OFF_N; n++) begin
            repeat (gap - 1) next_cycle();
            tick_once((n < ON_N) ? model_sample(rinc, cinc, n) : 0, n == ON_N + OFF_N - 1);
            if (n == intrude_after) begin
                start     = 1'b1;
                tone_code = 5'd1;
                next_cycle();
                start     = 1'b0;
            end
        end
        next_cycle();
        check("busy_drain", busy, 1);
        next_cycle();
        check("busy_fall", busy, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b1;
        tone_code   = 5'd5;
        sample_tick = 1'b0;

        // Reset held with start asserted
        next_cycle();
        next_cycle();
        check("rst_busy", busy, 0);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset_n = 1'b1;
        start   = 1'b0;
        next_cycle();
        check("idle_busy", busy, 0);

        // Tick while idle produces nothing
        sample_tick = 1'b1;
        next_cycle();
        sample_tick = 1'b0;
        repeat (4) next_cycle();
        check("idle_tick_busy", busy, 0);

        // Code 5 (770/1336 Hz), start coincident with a tick, ticks every 10 cycles
        run_digit(5, 1614807, 2801795, 10, 1'b1, -1);

        // Code 1 (697/1209 Hz) at the minimum tick spacing
        run_digit(1, 1461715, 2535457, 3, 1'b0, -1);

        // Invalid codes
        start = 1'b1; tone_code = 5'd16; err_q.push_back(cyc + 1);
        next_cycle();
        start = 1'b0;
        check("inv16_busy", busy, 0);
        repeat (3) next_cycle();
        start = 1'b1; tone_code = 5'd31; err_q.push_back(cyc + 1);
        next_cycle();
        start = 1'b0;
        check("inv31_busy", busy, 0);
        repeat (3) next_cycle();

        // Start during ON is ignored
        run_digit(5, 1614807, 2801795, 10, 1'b0, 1);

        // Reset during ON discards the in-flight sample
        start = 1'b1; tone_code = 5'd5;
        next_cycle();
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            repeat (3) next_cycle();
            tick_once(model_sample(1614807, 2801795, n), 1'b0);
        end
        reset_n = 1'b0;
        sb.delete();
        next_cycle();
        next_cycle();
        check("midrst_busy", busy, 0);
        check("midrst_sample", sample, 0);
        check("midrst_valid", sample_valid, 0);
        reset_n = 1'b1;
        repeat (3) next_cycle();
        check("midrst_idle_busy", busy, 0);

        // Code 0 (941/1336 Hz) after the reset
        run_digit(0, 1973420, 2801795, 4, 1'b0, -1);

        repeat (4) next_cycle();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
